// File: rtl/decode_pkg.sv
// Shared decode types: opcode/funct constants, ALU select codes, mux selects,
// the packed control bundle and the inert (all-zero) bundle used at reset.
package decode_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Original 4-bit codes zero-extended; M-extension codes occupy 16..23 as {2'b10, funct3}.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SLL    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SRL    = 5'd5,
        ALU_OR     = 5'd6,
        ALU_AND    = 5'd7,
        ALU_SUB    = 5'd12,
        ALU_SRA    = 5'd13,
        ALU_BSEL   = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic PC_PLUS4  = 1'b0;
    localparam logic PC_ALU    = 1'b1;
    localparam logic A_RS1     = 1'b0;
    localparam logic A_PC      = 1'b1;
    localparam logic B_RS2     = 1'b0;
    localparam logic B_IMM     = 1'b1;
    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;

    // isb = {is_branch, branch funct3}
    typedef struct packed {
        logic [3:0] isb;
        logic       pc_sel;
        logic [2:0] imm_sel;
        logic       br_un;
        logic       a_sel;
        logic       b_sel;
        alu_e       alu_sel;
        logic       mem_rw;
        logic       reg_wen;
        logic [1:0] wb_sel;
        logic       rd_valid;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_e a;
        a = ALU_ADD;
        case (f3)
            3'd0: a = alt ? ALU_SUB : ALU_ADD;
            3'd1: a = ALU_SLL;
            3'd2: a = ALU_SLT;
            3'd3: a = ALU_SLTU;
            3'd4: a = ALU_XOR;
            3'd5: a = alt ? ALU_SRA : ALU_SRL;
            3'd6: a = ALU_OR;
            3'd7: a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Combinational RV32I instruction decoder: control bundle, illegal flag, source usage.
// Define RV32M_EN to decode the M-extension; otherwise those encodings are illegal.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3
);

    logic [6:0] opcode;
    logic [6:0] f7;
    logic       bad;

    assign opcode = inst[6:0];
    assign f7     = inst[31:25];
    assign funct3 = inst[14:12];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2 = (opcode == OP_R || opcode == OP_S || opcode == OP_B);

    always_comb begin
        ctrl = CTRL_NOP;
        bad  = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_wen  = 1'b1;
                ctrl.rd_valid = 1'b1;
                ctrl.wb_sel   = WB_ALU;
                if (f7 == F7_BASE)
                    ctrl.alu_sel = alu_from_f3(funct3, 1'b0);
                else if (f7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))
                    ctrl.alu_sel = alu_from_f3(funct3, 1'b1);
`ifdef RV32M_EN
                else if (f7 == F7_MULDIV)
                    ctrl.alu_sel = alu_e'({2'b10, funct3});
`endif
                else
                    bad = 1'b1;
            end
            OP_I: begin
                ctrl.b_sel    = B_IMM;
                ctrl.alu_sel  = alu_from_f3(funct3, funct3 == F3_SRL_SRA && f7[5]);
                ctrl.reg_wen  = 1'b1;
                ctrl.rd_valid = 1'b1;
                ctrl.wb_sel   = WB_ALU;
            end
            OP_LOAD: begin
                ctrl.b_sel    = B_IMM;
                ctrl.reg_wen  = 1'b1;
                ctrl.rd_valid = 1'b1;
                ctrl.wb_sel   = WB_MEM;
                bad = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
            end
            OP_S: begin
                ctrl.imm_sel = IMM_S;
                ctrl.b_sel   = B_IMM;
                ctrl.mem_rw  = MEM_STORE;
                bad = !(funct3 inside {F3_SB, F3_SH, F3_SW});
            end
            OP_B: begin
                ctrl.isb     = {1'b1, funct3};
                ctrl.br_un   = funct3[1];
                ctrl.imm_sel = IMM_B;
                ctrl.a_sel   = A_PC;
                ctrl.b_sel   = B_IMM;
            end
            OP_JALR: begin
                ctrl.pc_sel   = PC_ALU;
                ctrl.b_sel    = B_IMM;
                ctrl.reg_wen  = 1'b1;
                ctrl.rd_valid = 1'b1;
                ctrl.wb_sel   = WB_PC4;
                bad = (funct3 != F3_JALR);
            end
            OP_JAL: begin
                ctrl.pc_sel   = PC_ALU;
                ctrl.imm_sel  = IMM_J;
                ctrl.a_sel    = A_PC;
                ctrl.b_sel    = B_IMM;
                ctrl.reg_wen  = 1'b1;
                ctrl.rd_valid = 1'b1;
                ctrl.wb_sel   = WB_PC4;
            end
            OP_LUI: begin
                ctrl.imm_sel  = IMM_U;
                ctrl.b_sel    = B_IMM;
                ctrl.alu_sel  = ALU_BSEL;
                ctrl.reg_wen  = 1'b1;
                ctrl.rd_valid = 1'b1;
                ctrl.wb_sel   = WB_ALU;
            end
            OP_AUIPC: begin
                ctrl.imm_sel  = IMM_U;
                ctrl.a_sel    = A_PC;
                ctrl.b_sel    = B_IMM;
                ctrl.reg_wen  = 1'b1;
                ctrl.rd_valid = 1'b1;
                ctrl.wb_sel   = WB_ALU;
            end
            default: bad = 1'b1;
        endcase

        if (inst[1:0] != 2'b11)
            bad = 1'b1;

        // Illegal words still flow to EX for trapping, but must have no architectural side effects.
        if (bad) begin
            ctrl.reg_wen  = 1'b0;
            ctrl.mem_rw   = MEM_LOAD;
            ctrl.rd_valid = 1'b0;
            ctrl.isb[3]   = 1'b0;
            ctrl.illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: ID/EX register with valid/ready, load-use hazard bubble,
// flush, and a saturating stall counter. RV32M_EN enables M-extension decode.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output ctrl_t            out_ctrl,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    ctrl_t      dec_ctrl;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [2:0] dec_funct3;
    logic       hazard;
    logic       accept;

    decode_comb u_decode (
        .inst     (in_inst),
        .ctrl     (dec_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .funct3   (dec_funct3)
    );

    // A load in ID/EX has no data until MEM, so a dependent instruction must wait one cycle.
    assign hazard = out_valid && out_ctrl.wb_sel == WB_MEM && out_ctrl.reg_wen
                 && out_rd != 5'd0 && in_valid
                 && ((uses_rs1 && dec_rs1 == out_rd) || (uses_rs2 && dec_rs2 == out_rd));

    assign in_ready = flush || (!hazard && (!out_valid || out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ctrl   <= CTRL_NOP;
            out_rd     <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_funct3 <= '0;
            out_inst   <= '0;
            out_pc     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_ctrl   <= dec_ctrl;
            out_rd     <= dec_rd;
            out_rs1    <= dec_rs1;
            out_rs2    <= dec_rs2;
            out_funct3 <= dec_funct3;
            out_inst   <= in_inst;
            out_pc     <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (hazard && !flush && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_ONE;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage: a mnemonic-level reference model
// predicts handshakes, stalls and the decoded bundle of every issued instruction.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    localparam int K_ADD = 0,  K_SUB = 1,  K_SRA = 2,   K_XOR = 3,  K_ADDI = 4;
    localparam int K_LW = 5,   K_LBU = 6,  K_SW = 7,    K_BEQ = 8,  K_BLTU = 9;
    localparam int K_JAL = 10, K_JALR = 11, K_LUI = 12, K_AUIPC = 13, K_MUL = 14;
    localparam int K_DIVU = 15, K_ILL0 = 16, K_ILLLD = 17, K_ILLR = 18, K_ILLS = 19;
    localparam int NK = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    ctrl_t            out_ctrl;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [2:0]       out_funct3;
    logic [31:0]      out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_funct3(out_funct3), .out_inst(out_inst),
        .out_pc(out_pc), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        ctrl_t           ctrl;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
    } txn_t;

    txn_t q[$];
    int n_err = 0;
    int n_chk = 0;
    int n_txn = 0;

    // Model of the ID/EX register contents that matter for hazards.
    bit               m_valid = 1'b0;
    bit               m_load  = 1'b0;
    logic [4:0]       m_rd    = '0;
    logic [CNT_W-1:0] m_stall = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ctrl_t writes(input ctrl_t c, input logic [1:0] wb);
        c.reg_wen  = 1'b1;
        c.rd_valid = 1'b1;
        c.wb_sel   = wb;
        return c;
    endfunction

    // Encode one mnemonic and state what it must decode to.
    function automatic void gen(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, output txn_t t,
                                output bit u1, output bit u2, output bit ld);
        logic [6:0] op, f7;
        logic [2:0] f3;
        ctrl_t c;
        f7 = 7'($urandom);
        f3 = 3'($urandom);
        op = 7'd0;
        c  = '0;
        u1 = 1'b1;
        u2 = 1'b0;
        ld = 1'b0;
        case (k)
            K_ADD:  begin op = OP_R; f7 = 7'b0000000; f3 = 3'd0; c.alu_sel = ALU_ADD; c = writes(c, WB_ALU); u2 = 1; end
            K_SUB:  begin op = OP_R; f7 = 7'b0100000; f3 = 3'd0; c.alu_sel = ALU_SUB; c = writes(c, WB_ALU); u2 = 1; end
            K_SRA:  begin op = OP_R; f7 = 7'b0100000; f3 = 3'd5; c.alu_sel = ALU_SRA; c = writes(c, WB_ALU); u2 = 1; end
            K_XOR:  begin op = OP_R; f7 = 7'b0000000; f3 = 3'd4; c.alu_sel = ALU_XOR; c = writes(c, WB_ALU); u2 = 1; end
            K_ADDI: begin op = OP_I; f3 = 3'd0; c.imm_sel = IMM_I; c.b_sel = B_IMM; c = writes(c, WB_ALU); end
            K_LW:   begin op = OP_LOAD; f3 = 3'd2; c.imm_sel = IMM_I; c.b_sel = B_IMM; c = writes(c, WB_MEM); ld = 1; end
            K_LBU:  begin op = OP_LOAD; f3 = 3'd4; c.imm_sel = IMM_I; c.b_sel = B_IMM; c = writes(c, WB_MEM); ld = 1; end
            K_SW:   begin op = OP_S; f3 = 3'd2; c.imm_sel = IMM_S; c.b_sel = B_IMM; c.mem_rw = MEM_STORE; u2 = 1; end
            K_BEQ:  begin op = OP_B; f3 = 3'd0; c.isb = 4'b1000; c.imm_sel = IMM_B; c.a_sel = A_PC; c.b_sel = B_IMM; u2 = 1; end
            K_BLTU: begin op = OP_B; f3 = 3'd6; c.isb = 4'b1110; c.br_un = 1'b1; c.imm_sel = IMM_B; c.a_sel = A_PC; c.b_sel = B_IMM; u2 = 1; end
            K_JAL:  begin op = OP_JAL; c.pc_sel = PC_ALU; c.imm_sel = IMM_J; c.a_sel = A_PC; c.b_sel = B_IMM; c = writes(c, WB_PC4); u1 = 0; end
            K_JALR: begin op = OP_JALR; f3 = 3'd0; c.pc_sel = PC_ALU; c.imm_sel = IMM_I; c.b_sel = B_IMM; c = writes(c, WB_PC4); end
            K_LUI:  begin op = OP_LUI; c.imm_sel = IMM_U; c.b_sel = B_IMM; c.alu_sel = ALU_BSEL; c = writes(c, WB_ALU); u1 = 0; end
            K_AUIPC: begin op = OP_AUIPC; c.imm_sel = IMM_U; c.a_sel = A_PC; c.b_sel = B_IMM; c = writes(c, WB_ALU); u1 = 0; end
            K_MUL, K_DIVU: begin
                op = OP_R; f7 = 7'b0000001; f3 = (k == K_MUL) ? 3'd0 : 3'd5; u2 = 1;
`ifdef RV32M_EN
                c.alu_sel = (k == K_MUL) ? ALU_MUL : ALU_DIVU;
                c = writes(c, WB_ALU);
`else
                c.illegal = 1'b1;
`endif
            end
            K_ILL0:  begin op = 7'd0; f7 = 7'd0; f3 = 3'd0; c.illegal = 1'b1; end
            K_ILLLD: begin op = OP_LOAD; f3 = 3'd3; c.illegal = 1'b1; end
            K_ILLR:  begin op = OP_R; f7 = 7'b0100000; f3 = 3'd1; c.illegal = 1'b1; u2 = 1; end
            K_ILLS:  begin op = OP_S; f3 = 3'd3; c.illegal = 1'b1; u2 = 1; end
            default: begin op = 7'd0; c.illegal = 1'b1; end
        endcase
        t.rd   = (k == K_ILL0) ? 5'd0 : rd;
        t.rs1  = (k == K_ILL0) ? 5'd0 : rs1;
        t.rs2  = (k == K_ILL0) ? 5'd0 : rs2;
        t.f3   = f3;
        t.ctrl = c;
        t.pc   = '0;
        t.inst = {f7, t.rs2, t.rs1, f3, t.rd, op};
    endfunction

    // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input int k, input int rd, input int rs1, input int rs2,
                         input bit v, input bit r, input bit f);
        txn_t t;
        bit u1, u2, ld, hz, rdy;
        gen(k, 5'(rd), 5'(rs1), 5'(rs2), t, u1, u2, ld);
        t.pc      = XLEN'($urandom & 32'hFFFF_FFFC);
        in_valid  = v;
        in_inst   = t.inst;
        in_pc     = t.pc;
        out_ready = r;
        flush     = f;
        #1;
        hz  = m_valid && m_load && m_rd != 5'd0 && v
           && ((u1 && t.rs1 == m_rd) || (u2 && t.rs2 == m_rd));
        rdy = f || (!hz && (!m_valid || r));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (hz && !f && m_stall != '1)
            m_stall = m_stall + 1'b1;
        if (f) begin
            if (m_valid) void'(q.pop_back());
            m_valid = 1'b0;
        end else if (v && rdy) begin
            q.push_back(t);
            m_valid = 1'b1;
            m_load  = ld;
            m_rd    = t.rd;
        end else if (r) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        q.delete();
        m_valid = 1'b0;
        m_load  = 1'b0;
        m_stall = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every consumed ID/EX entry is compared against the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            txn_t e;
            if (q.size() == 0) begin
                chk("mon_underflow", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                n_txn++;
                if (e.ctrl.illegal)
                    chk("ctrl_illegal", 64'({out_ctrl.illegal, out_ctrl.reg_wen, out_ctrl.mem_rw,
                                             out_ctrl.rd_valid, out_ctrl.isb[3]}), 64'(5'b10000));
                else
                    chk("ctrl", 64'(out_ctrl), 64'(e.ctrl));
                chk("inst", 64'(out_inst), 64'(e.inst));
                chk("pc", 64'(out_pc), 64'(e.pc));
                chk("fields", 64'({out_rd, out_rs1, out_rs2, out_funct3}),
                    64'({e.rd, e.rs1, e.rs2, e.f3}));
                $display("txn %0d pc=%08h inst=%08h alu=%0d illegal=%0b", n_txn, out_pc,
                         out_inst, out_ctrl.alu_sel, out_ctrl.illegal);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_ctrl", 64'(out_ctrl), 64'd0);
        chk("reset_idx", 64'({out_rd, out_rs1, out_rs2, out_funct3}), 64'd0);
        chk("reset_inst", 64'(out_inst), 64'd0);
        chk("reset_pc", 64'(out_pc), 64'd0);
        chk("reset_stall", 64'(stall_cnt), 64'd0);
        rst = 1'b0;

        // ADD x3,x1,x2
        cycle(K_ADD, 3, 1, 2, 1, 1, 0);
        cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        // LW x5 then dependent ADD: one bubble, one stall
        cycle(K_LW, 5, 1, 0, 1, 1, 0);
        cycle(K_ADD, 6, 5, 2, 1, 1, 0);
        cycle(K_ADD, 6, 5, 2, 1, 1, 0);
        chk("plan_stall_one", 64'(stall_cnt), 64'd1);
        cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        // LW x0 then ADD reading x0: no stall
        cycle(K_LW, 0, 1, 0, 1, 1, 0);
        cycle(K_ADD, 6, 0, 2, 1, 1, 0);
        cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        chk("plan_x0_nostall", 64'(stall_cnt), 64'd1);
        // BEQ registered, flush while SUB presented
        cycle(K_BEQ, 0, 1, 2, 1, 1, 0);
        cycle(K_SUB, 4, 1, 2, 1, 0, 1);
        cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        // illegal encodings and M-extension
        cycle(K_ILL0, 0, 0, 0, 1, 1, 0);
        cycle(K_ILLLD, 2, 1, 0, 1, 1, 0);
        cycle(K_MUL, 7, 1, 2, 1, 1, 0);
        cycle(K_DIVU, 7, 1, 2, 1, 1, 0);
        cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        // back-pressure held for three cycles
        cycle(K_ADDI, 4, 1, 0, 1, 1, 0);
        repeat (3) cycle(K_XOR, 5, 1, 2, 1, 0, 0);
        cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        // reset while a load-use hazard is pending
        cycle(K_LW, 3, 1, 0, 1, 0, 0);
        cycle(K_ADD, 4, 3, 3, 1, 0, 0);
        do_reset();

        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, NK - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom % 4) != 0, ($urandom % 4) != 0,
                  ($urandom % 16) == 0);
        end

        repeat (4) cycle(K_ADD, 0, 0, 0, 0, 1, 0);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
